// File: rtl/pipeline_redirect_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_redirect_ctrl_if
// Bundles the redirect requests from EX/WB, the stage stall requests, the
// per-stage flush/stall vectors and the redirect handshake to fetch.
//   master : the core side (drives requests and fetch_ready, observes controls)
//   slave  : the redirect controller
// Parameter ADDR_WIDTH : width of every PC / target.
// ----------------------------------------------------------------------------
interface pipeline_redirect_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  bru_miss_valid;
    logic [ADDR_WIDTH-1:0] bru_miss_target;
    logic                  exc_valid;
    logic [ADDR_WIDTH-1:0] exc_entry;
    logic                  ertn_valid;
    logic [ADDR_WIDTH-1:0] era;
    logic                  if_stall_req;
    logic                  mem_stall_req;
    logic                  fetch_ready;
    logic [4:0]            flush;
    logic [4:0]            stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  redirect_busy;

    modport master (
        output bru_miss_valid, bru_miss_target, exc_valid, exc_entry,
               ertn_valid, era, if_stall_req, mem_stall_req, fetch_ready,
        input  flush, stall, redirect_valid, redirect_pc, redirect_busy
    );

    modport slave (
        input  bru_miss_valid, bru_miss_target, exc_valid, exc_entry,
               ertn_valid, era, if_stall_req, mem_stall_req, fetch_ready,
        output flush, stall, redirect_valid, redirect_pc, redirect_busy
    );
endinterface

// File: rtl/pipeline_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_redirect_ctrl
// Stall/flush/redirect sequencer for the 5-stage core (IF,ID,EX,MEM,WB).
// Picks one redirect request by age (exc > ertn > bru_miss), drives the
// per-stage flush/stall vectors and presents the redirect PC to fetch over a
// valid/ready handshake, parking it in PEND until fetch accepts.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   bus (slave)     requests, flush[4:0]/stall[4:0] ([4]=IF .. [0]=WB),
//                   redirect_valid/redirect_pc/fetch_ready, redirect_busy
// Optional (macro PIPE_CTRL_PERF_EN):
//   o_perf_redirects     accepted handshakes, wraps mod 2^32
//   o_perf_stall_cycles  cycles with stall != 0, wraps mod 2^32
// ----------------------------------------------------------------------------
module pipeline_redirect_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    pipeline_redirect_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]              o_perf_redirects,
    output logic [31:0]              o_perf_stall_cycles
`endif
);
    typedef enum logic {S_IDLE, S_PEND} state_e;
    typedef enum logic [1:0] {K_NONE, K_BRU, K_EXC, K_ERTN} kind_e;

    state_e                r_state, w_state_nxt;
    kind_e                 r_pend_kind, w_kind_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_pc, w_pc_nxt;

    logic                  w_acc;
    kind_e                 w_acc_kind;
    logic [ADDR_WIDTH-1:0] w_acc_pc;
    logic [4:0]            w_flush, w_stall;
    logic                  w_valid, w_busy;
    logic [ADDR_WIDTH-1:0] w_rpc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_pend_kind <= K_NONE;
            r_pend_pc   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_kind <= w_kind_nxt;
            r_pend_pc   <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_pend_kind;
        w_pc_nxt    = r_pend_pc;
        w_acc       = 1'b0;
        w_acc_kind  = K_NONE;
        w_acc_pc    = '0;
        w_flush     = 5'b00000;
        w_stall     = 5'b00000;
        w_valid     = 1'b0;
        w_rpc       = '0;
        w_busy      = (r_state == S_PEND);

        // Age priority. A mispredict is only taken while MEM is not frozen
        // (EX re-asserts later), and is younger than any pending WB redirect,
        // so it is dropped when PEND holds an exc/ertn.
        if (bus.exc_valid) begin
            w_acc      = 1'b1;
            w_acc_kind = K_EXC;
            w_acc_pc   = bus.exc_entry;
        end else if (bus.ertn_valid) begin
            w_acc      = 1'b1;
            w_acc_kind = K_ERTN;
            w_acc_pc   = bus.era;
        end else if (bus.bru_miss_valid && !bus.mem_stall_req &&
                     (r_state == S_IDLE || r_pend_kind == K_BRU)) begin
            w_acc      = 1'b1;
            w_acc_kind = K_BRU;
            w_acc_pc   = bus.bru_miss_target;
        end

        if (w_acc)
            w_flush = (w_acc_kind == K_BRU) ? 5'b11000 : 5'b11110;

        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_valid = 1'b1;
                    w_rpc   = w_acc_pc;
                    if (!bus.fetch_ready) begin
                        w_state_nxt = S_PEND;
                        w_kind_nxt  = w_acc_kind;
                        w_pc_nxt    = w_acc_pc;
                    end
                end
            end
            S_PEND: begin
                // Keep killing whatever IF fetched down the wrong path.
                w_flush[4] = 1'b1;
                w_valid    = 1'b1;
                w_rpc      = w_acc ? w_acc_pc : r_pend_pc;
                if (w_acc) begin
                    w_kind_nxt = w_acc_kind;
                    w_pc_nxt   = w_acc_pc;
                end
                if (bus.fetch_ready) begin
                    w_state_nxt = S_IDLE;
                    w_kind_nxt  = K_NONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (bus.mem_stall_req)
            w_stall = 5'b11110;
        else if (bus.if_stall_req)
            w_stall = 5'b10000;
        // A flushed stage must load its bubble, so it can never be held.
        w_stall = w_stall & ~w_flush;

        // Outputs are forced quiet for the whole reset window.
        if (!i_rst_n) begin
            w_flush = 5'b00000;
            w_stall = 5'b00000;
            w_valid = 1'b0;
            w_rpc   = '0;
            w_busy  = 1'b0;
        end
    end

    assign bus.flush          = w_flush;
    assign bus.stall          = w_stall;
    assign bus.redirect_valid = w_valid;
    assign bus.redirect_pc    = w_rpc;
    assign bus.redirect_busy  = w_busy;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_redirects, r_perf_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_perf_redirects    <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if (w_valid && bus.fetch_ready)
                r_perf_redirects <= r_perf_redirects + 32'd1;
            if (w_stall != 5'b00000)
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
        end
    end

    assign o_perf_redirects    = r_perf_redirects;
    assign o_perf_stall_cycles = r_perf_stall_cycles;
`endif
endmodule

// File: tb/tb_pipeline_redirect_ctrl.sv
module tb_pipeline_redirect_ctrl;
    localparam int AW = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipeline_redirect_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_redirects, perf_stall_cycles;
`endif

    pipeline_redirect_ctrl #(.ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .o_perf_redirects    (perf_redirects),
        .o_perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.bru_miss_valid  = 1'b0;
        bus.bru_miss_target = '0;
        bus.exc_valid       = 1'b0;
        bus.exc_entry       = '0;
        bus.ertn_valid      = 1'b0;
        bus.era             = '0;
        bus.if_stall_req    = 1'b0;
        bus.mem_stall_req   = 1'b0;
        bus.fetch_ready     = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later,
    // well before the next rising edge.
    task automatic step();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] fl, input logic [4:0] st,
                           input logic v, input logic [AW-1:0] pc, input logic busy);
        chk({tag, ".flush"}, 64'(bus.flush), 64'(fl));
        chk({tag, ".stall"}, 64'(bus.stall), 64'(st));
        chk({tag, ".valid"}, 64'(bus.redirect_valid), 64'(v));
        chk({tag, ".pc"},    64'(bus.redirect_pc), 64'(pc));
        chk({tag, ".busy"},  64'(bus.redirect_busy), 64'(busy));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();

        // Reset: outputs quiet even with requests asserted.
        step(); step();
        bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h1c000100;
        bus.exc_valid = 1'b1; bus.exc_entry = 32'h1c008000;
        bus.mem_stall_req = 1'b1; bus.fetch_ready = 1'b1;
        settle(); chk_out("in_reset", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);
        step(); rst_n = 1'b1; settle();
        chk_out("post_reset", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_redir_rst", 64'(perf_redirects), 64'd0);
        chk("perf_stall_rst", 64'(perf_stall_cycles), 64'd0);
`endif

        // Mispredict, fetch ready: zero-latency redirect.
        step();
        bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h1c000100; bus.fetch_ready = 1'b1;
        settle(); chk_out("bru_rdy", 5'b11000, 5'b00000, 1'b1, 32'h1c000100, 1'b0);
        step(); settle(); chk_out("bru_after", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Exception beats a same-cycle mispredict.
        step();
        bus.exc_valid = 1'b1; bus.exc_entry = 32'h1c008000;
        bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h1c000100; bus.fetch_ready = 1'b1;
        settle(); chk_out("exc_bru", 5'b11110, 5'b00000, 1'b1, 32'h1c008000, 1'b0);

        // Exception beats a same-cycle ertn.
        step();
        bus.exc_valid = 1'b1; bus.exc_entry = 32'h1c00a000;
        bus.ertn_valid = 1'b1; bus.era = 32'h1c000040; bus.fetch_ready = 1'b1;
        settle(); chk_out("exc_ertn", 5'b11110, 5'b00000, 1'b1, 32'h1c00a000, 1'b0);

        // ertn with fetch stalled for three cycles.
        step();
        bus.ertn_valid = 1'b1; bus.era = 32'h1c000040;
        settle(); chk_out("ertn_c1", 5'b11110, 5'b00000, 1'b1, 32'h1c000040, 1'b0);
        step(); settle(); chk_out("ertn_c2", 5'b10000, 5'b00000, 1'b1, 32'h1c000040, 1'b1);
        step(); settle(); chk_out("ertn_c3", 5'b10000, 5'b00000, 1'b1, 32'h1c000040, 1'b1);
        step(); bus.fetch_ready = 1'b1;
        settle(); chk_out("ertn_c4", 5'b10000, 5'b00000, 1'b1, 32'h1c000040, 1'b1);
        step(); settle(); chk_out("ertn_done", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Mispredict blocked by a MEM stall, taken once the stall clears.
        step();
        bus.mem_stall_req = 1'b1; bus.bru_miss_valid = 1'b1;
        bus.bru_miss_target = 32'h1c000200; bus.fetch_ready = 1'b1;
        settle(); chk_out("bru_memstall", 5'b00000, 5'b11110, 1'b0, 32'h0, 1'b0);
        step();
        bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h1c000200; bus.fetch_ready = 1'b1;
        settle(); chk_out("bru_unstall", 5'b11000, 5'b00000, 1'b1, 32'h1c000200, 1'b0);

        // Stall priority and flush-overrides-stall.
        step(); bus.if_stall_req = 1'b1;
        settle(); chk_out("if_stall", 5'b00000, 5'b10000, 1'b0, 32'h0, 1'b0);
        step(); bus.if_stall_req = 1'b1; bus.mem_stall_req = 1'b1;
        settle(); chk_out("mem_over_if", 5'b00000, 5'b11110, 1'b0, 32'h0, 1'b0);
        step();
        bus.if_stall_req = 1'b1; bus.bru_miss_valid = 1'b1;
        bus.bru_miss_target = 32'h1c000300; bus.fetch_ready = 1'b1;
        settle(); chk_out("if_stall_bru", 5'b11000, 5'b00000, 1'b1, 32'h1c000300, 1'b0);
        step();
        bus.mem_stall_req = 1'b1; bus.exc_valid = 1'b1;
        bus.exc_entry = 32'h1c008000; bus.fetch_ready = 1'b1;
        settle(); chk_out("mem_stall_exc", 5'b11110, 5'b00000, 1'b1, 32'h1c008000, 1'b0);

        // PEND(BRU) overwritten by an exception.
        step(); bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h100;
        settle(); chk_out("pb_enter", 5'b11000, 5'b00000, 1'b1, 32'h100, 1'b0);
        step(); bus.exc_valid = 1'b1; bus.exc_entry = 32'h8000;
        settle(); chk_out("pb_exc", 5'b11110, 5'b00000, 1'b1, 32'h8000, 1'b1);
        step(); bus.fetch_ready = 1'b1;
        settle(); chk_out("pb_hs", 5'b10000, 5'b00000, 1'b1, 32'h8000, 1'b1);
        step(); settle(); chk_out("pb_done", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // PEND(EXC) ignores a younger mispredict.
        step(); bus.exc_valid = 1'b1; bus.exc_entry = 32'h200;
        settle(); chk("pe_enter.pc", 64'(bus.redirect_pc), 64'h200);
        step(); bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h300;
        settle(); chk_out("pe_bru", 5'b10000, 5'b00000, 1'b1, 32'h200, 1'b1);
        step(); bus.fetch_ready = 1'b1;
        settle(); chk_out("pe_hs", 5'b10000, 5'b00000, 1'b1, 32'h200, 1'b1);

        // PEND(BRU) overwritten by a newer mispredict.
        step(); bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h400;
        settle(); chk("pbb_enter.pc", 64'(bus.redirect_pc), 64'h400);
        step(); bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h500;
        settle(); chk_out("pbb_bru", 5'b11000, 5'b00000, 1'b1, 32'h500, 1'b1);
        step(); bus.fetch_ready = 1'b1;
        settle(); chk_out("pbb_hs", 5'b10000, 5'b00000, 1'b1, 32'h500, 1'b1);
        step(); settle(); chk_out("pbb_done", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Reset during PEND discards the pending redirect.
        step(); bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h600;
        settle(); chk("pr_enter.valid", 64'(bus.redirect_valid), 64'd1);
        step(); rst_n = 1'b0; bus.fetch_ready = 1'b1;
        settle(); chk_out("pr_in_reset", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);
        step(); rst_n = 1'b1; bus.fetch_ready = 1'b1;
        settle(); chk_out("pr_after", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_redir_rst2", 64'(perf_redirects), 64'd0);
        chk("perf_stall_rst2", 64'(perf_stall_cycles), 64'd0);
        step(); bus.mem_stall_req = 1'b1;
        step(); bus.bru_miss_valid = 1'b1; bus.bru_miss_target = 32'h700; bus.fetch_ready = 1'b1;
        step(); settle();
        chk("perf_redir_cnt", 64'(perf_redirects), 64'd1);
        chk("perf_stall_cnt", 64'(perf_stall_cycles), 64'd1);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
